// File: rtl/single_vector_gather_pkg.sv
// Shared single-precision definitions for the vector datapath blocks.
// Elements are carried as raw IEEE-754 bit patterns; nothing here does arithmetic.
package single_vector_gather_pkg;

    typedef logic [31:0] float32_t;

    localparam float32_t FP32_ZERO = 32'h0000_0000;

endpackage : single_vector_gather_pkg

// File: rtl/single_vector_gather_if.sv
// Element stream in, assembled vector out, for the serial-to-parallel gatherer.
//
// Stream semantics: there is no ready signal. Every cycle with in_valid = 1
// transfers `a` into the gatherer; in_last marks the final element of a vector
// and is meaningless while in_valid = 0. On the output side out_valid is a
// single-cycle pulse that marks a fresh vector_c/out_count; the consumer must
// take it on that cycle because vector_c is overwritten by the next completion.
interface single_vector_gather_if
    import single_vector_gather_pkg::*;
#(
    parameter int WIDTH = 10
);

    logic                           in_valid;
    logic                           in_last;
    float32_t                       a;

    logic                           out_valid;
    float32_t                       vector_c [WIDTH];
    logic [$clog2(WIDTH+1)-1:0]     out_count;

    // Producer side (scalar stream source, result sink).
    modport master (
        output in_valid,
        output in_last,
        output a,
        input  out_valid,
        input  vector_c,
        input  out_count
    );

    // Gatherer side.
    modport slave (
        input  in_valid,
        input  in_last,
        input  a,
        output out_valid,
        output vector_c,
        output out_count
    );

endinterface : single_vector_gather_if

// File: rtl/single_vector_gather.sv
// Serial-to-parallel gatherer: packs one fp32 element per cycle into a
// WIDTH-element vector, zero-pads short vectors and pulses out_valid once per
// completed vector. Zero bubble between vectors; feeds the summation tree.
module single_vector_gather
    import single_vector_gather_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    single_vector_gather_if.slave bus
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH+1);

    logic [IDX_W-1:0] idx;
    float32_t         buf_q     [WIDTH];
    float32_t         slot_next [WIDTH];
    float32_t         vec_q     [WIDTH];
    logic [CNT_W-1:0] count_q;
    logic             valid_q;
    logic             complete;

    // A vector closes on an accepted element that is flagged last or fills the final slot.
    assign complete = bus.in_valid && (bus.in_last || (idx == IDX_W'(WIDTH-1)));

    // Write index: advances per accepted element, returns to slot 0 on completion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx <= '0;
        end else if (bus.in_valid) begin
            if (complete) begin
                idx <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Collection buffer: never cleared, stale slots are masked at completion.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (idx == IDX_W'(k)) begin
                    buf_q[k] <= bus.a;
                end
            end
        end
    end

    // Per-slot mask: earlier slots from the buffer, the current slot straight
    // from the input (it has not reached the buffer yet), later slots padded.
    for (genvar k = 0; k < WIDTH; k++) begin : g_slot
        assign slot_next[k] = (IDX_W'(k) < idx)  ? buf_q[k] :
                              (IDX_W'(k) == idx) ? bus.a    :
                                                   FP32_ZERO;
    end

    // Output registers: vector and count hold until the next completion, valid pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            count_q <= '0;
            for (int k = 0; k < WIDTH; k++) begin
                vec_q[k] <= FP32_ZERO;
            end
        end else begin
            valid_q <= complete;
            if (complete) begin
                count_q <= CNT_W'(idx) + CNT_W'(1);
                for (int k = 0; k < WIDTH; k++) begin
                    vec_q[k] <= slot_next[k];
                end
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_count = count_q;
    assign bus.vector_c  = vec_q;

endmodule : single_vector_gather

// File: tb/tb_single_vector_gather.sv
// Directed bench for single_vector_gather with WIDTH = 10: a table of
// per-cycle stimulus/expectation rows plus hand-written multi-cycle sequences.
module tb_single_vector_gather;
    import single_vector_gather_pkg::*;

    localparam int WIDTH = 10;

    // Clock / reset
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    single_vector_gather_if #(.WIDTH(WIDTH)) bus ();

    single_vector_gather #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks    = 0;
    int errors    = 0;
    int pulse_cnt = 0;

    // Scoreboard of expected slot values for the next full-vector comparison
    logic [31:0] exp_q [$];

    // Pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) pulse_cnt++;
    end

    typedef struct {
        logic        v;
        logic        l;
        float32_t    a;
        logic        ev;
        logic [3:0]  ecnt;
        float32_t    s0;
        float32_t    s1;
        float32_t    s2;
        float32_t    s9;
    } row_t;

    row_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, return 1 time unit after the edge
    task automatic drive(input logic v, input logic l, input float32_t d);
        bus.in_valid = v;
        bus.in_last  = l;
        bus.a        = d;
        @(posedge clk);
        #1;
    endtask

    // Compare the whole output vector against exp_q (WIDTH entries)
    task automatic check_vector(input string name, input logic [3:0] exp_cnt);
        logic [31:0] e;
        check({name, "_count"}, 32'(bus.out_count), 32'(exp_cnt));
        for (int k = 0; k < WIDTH; k++) begin
            if (exp_q.size() == 0) begin
                check({name, "_scoreboard_empty"}, 32'd0, 32'd1);
                break;
            end
            e = exp_q.pop_front();
            check($sformatf("%s_slot%0d", name, k), bus.vector_c[k], e);
        end
    endtask

    initial begin
        int p0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.a        = '0;

        tbl[0]  = '{1'b1, 1'b0, 32'h3F80_0000, 1'b0, 4'd10, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
        tbl[1]  = '{1'b1, 1'b0, 32'h4000_0000, 1'b0, 4'd10, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
        tbl[2]  = '{1'b1, 1'b1, 32'h4040_0000, 1'b1, 4'd3,  32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 4'd3,  32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 32'h4000_0000, 1'b0, 4'd3,  32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h0};
        tbl[5]  = '{1'b1, 1'b1, 32'h4000_0000, 1'b1, 4'd2,  32'h4000_0000, 32'h4000_0000, 32'h0,         32'h0};
        tbl[6]  = '{1'b1, 1'b1, 32'h3F80_0000, 1'b1, 4'd1,  32'h3F80_0000, 32'h0,         32'h0,         32'h0};
        tbl[7]  = '{1'b1, 1'b1, 32'h4000_0000, 1'b1, 4'd1,  32'h4000_0000, 32'h0,         32'h0,         32'h0};
        tbl[8]  = '{1'b1, 1'b1, 32'h4040_0000, 1'b1, 4'd1,  32'h4040_0000, 32'h0,         32'h0,         32'h0};
        tbl[9]  = '{1'b1, 1'b1, 32'h4080_0000, 1'b1, 4'd1,  32'h4080_0000, 32'h0,         32'h0,         32'h0};
        tbl[10] = '{1'b1, 1'b1, 32'h40A0_0000, 1'b1, 4'd1,  32'h40A0_0000, 32'h0,         32'h0,         32'h0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,         1'b0, 4'd1,  32'h40A0_0000, 32'h0,         32'h0,         32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < WIDTH; k++) exp_q.push_back(32'h0);
        check_vector("reset", 4'd0);
        rstn = 1'b1;

        // Full vector: ten 1.0 elements, no in_last
        for (int i = 0; i < WIDTH; i++) begin
            drive(1'b1, 1'b0, 32'h3F80_0000);
            if (i < WIDTH-1) check($sformatf("full_early_valid%0d", i), 32'(bus.out_valid), 32'd0);
        end
        check("full_valid", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < WIDTH; k++) exp_q.push_back(32'h3F80_0000);
        check_vector("full", 4'd10);
        drive(1'b0, 1'b0, 32'h0);
        check("full_pulse_end", 32'(bus.out_valid), 32'd0);

        // Short vectors, stale-slot masking, single-element stream
        for (int r = 0; r < 12; r++) begin
            drive(tbl[r].v, tbl[r].l, tbl[r].a);
            check($sformatf("tbl%0d_valid", r), 32'(bus.out_valid), 32'(tbl[r].ev));
            check($sformatf("tbl%0d_count", r), 32'(bus.out_count), 32'(tbl[r].ecnt));
            check($sformatf("tbl%0d_s0", r), bus.vector_c[0], tbl[r].s0);
            check($sformatf("tbl%0d_s1", r), bus.vector_c[1], tbl[r].s1);
            check($sformatf("tbl%0d_s2", r), bus.vector_c[2], tbl[r].s2);
            check($sformatf("tbl%0d_s9", r), bus.vector_c[9], tbl[r].s9);
        end

        // Back-to-back: 10-element vector then 4-element vector, no gap
        p0 = pulse_cnt;
        for (int i = 0; i < WIDTH; i++) drive(1'b1, 1'b0, 32'h1000_0000 + 32'(i));
        check("b2b_first_valid", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < WIDTH; k++) exp_q.push_back(32'h1000_0000 + 32'(k));
        check_vector("b2b_first", 4'd10);
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, (j == 3), 32'h2000_0000 + 32'(j));
            if (j < 3) begin
                check($sformatf("b2b_gap_valid%0d", j), 32'(bus.out_valid), 32'd0);
                check($sformatf("b2b_hold_count%0d", j), 32'(bus.out_count), 32'd10);
                check($sformatf("b2b_hold_s0_%0d", j), bus.vector_c[0], 32'h1000_0000);
                check($sformatf("b2b_hold_s9_%0d", j), bus.vector_c[9], 32'h1000_0009);
            end
        end
        check("b2b_second_valid", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < WIDTH; k++) exp_q.push_back((k < 4) ? 32'h2000_0000 + 32'(k) : 32'h0);
        check_vector("b2b_second", 4'd4);
        drive(1'b0, 1'b0, 32'h0);
        check("b2b_pulses", 32'(pulse_cnt - p0), 32'd2);

        // Gaps inside a vector, in_last on the 10th element
        p0 = pulse_cnt;
        for (int i = 0; i < WIDTH; i++) begin
            repeat ($urandom_range(0, 2)) drive(1'b0, 1'b1, 32'hDEAD_BEEF);
            drive(1'b1, (i == WIDTH-1), 32'h3000_0000 + 32'(i));
        end
        check("gap_valid", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < WIDTH; k++) exp_q.push_back(32'h3000_0000 + 32'(k));
        check_vector("gap", 4'd10);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        check("gap_pulses", 32'(pulse_cnt - p0), 32'd1);

        // Reset after 6 elements of a vector
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 32'h5000_0000 + 32'(i));
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rstn = 1'b0;
        #1;
        check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_count", 32'(bus.out_count), 32'd0);
        check("rst_mid_s0", bus.vector_c[0], 32'h0);
        check("rst_mid_s9", bus.vector_c[9], 32'h0);
        repeat (2) @(posedge clk);
        #1;
        p0 = pulse_cnt;
        rstn = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 32'h0);
        check("rst_mid_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, (i == 2), 32'h6000_0000 + 32'(i));
            if (i < 2) check($sformatf("post_rst_early_valid%0d", i), 32'(bus.out_valid), 32'd0);
        end
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < WIDTH; k++) exp_q.push_back((k < 3) ? 32'h6000_0000 + 32'(k) : 32'h0);
        check_vector("post_rst", 4'd3);

        // Reset while out_valid is high clears it immediately
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        #1;
        rstn = 1'b0;
        #1;
        check("rst_pulse_valid", 32'(bus.out_valid), 32'd0);
        check("rst_pulse_count", 32'(bus.out_count), 32'd0);
        check("rst_pulse_s0", bus.vector_c[0], 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b1, 1'b1, 32'h7000_0001);
        check("after_rst_valid", 32'(bus.out_valid), 32'd1);
        check("after_rst_count", 32'(bus.out_count), 32'd1);
        check("after_rst_s0", bus.vector_c[0], 32'h7000_0001);
        check("after_rst_s1", bus.vector_c[1], 32'h0);
        drive(1'b0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_single_vector_gather
